axi4_memop_master: RTL

// Initiator-side AXI4 bridge: converts the single-word core memory interface (memop/memaddr/memdatain/

---
 rtl/axi4_memop_master_pkg.sv | 34 +++
 rtl/axi4_memop_master.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/axi4_memop_master_pkg.sv
// axi4_memop_master_pkg: AXI4 response/burst codes and byte-select to size/offset decode
package axi4_memop_master_pkg;

    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [3:0] AXI_CACHE   = 4'b0011;

    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WRESP} state_e;

    typedef struct packed {
        logic [2:0] size;
        logic [1:0] off;
    } sizeoff_t;

    // Single byte lanes and aligned halfwords map to narrow transfers; anything else is a full word.
    function automatic sizeoff_t axi4strb2size(input logic [3:0] bsel);
        case (bsel)
            4'b0001: return '{size: 3'd0, off: 2'd0};
            4'b0010: return '{size: 3'd0, off: 2'd1};
            4'b0100: return '{size: 3'd0, off: 2'd2};
            4'b1000: return '{size: 3'd0, off: 2'd3};
            4'b0011: return '{size: 3'd1, off: 2'd0};
            4'b1100: return '{size: 3'd1, off: 2'd2};
            default: return '{size: 3'd2, off: 2'd0};
        endcase
    endfunction

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/axi4_memop_master.sv
// axi4_memop_master: single-word core memory port to single-beat AXI4 master bridge
module axi4_memop_master
    import axi4_memop_master_pkg::*;
#(
    parameter int                            C_M_AXI_ID_WIDTH   = 4,
    parameter int                            C_M_AXI_ADDR_WIDTH = 32,
    parameter int                            C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ID_WIDTH-1:0]   C_M_AXI_ID         = '0,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_M_AXI_BASEADDR   = '0
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,
    input  logic [1:0]                      memop,
    input  logic [C_M_AXI_ADDR_WIDTH-3:0]   memaddr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   memdatain,
    input  logic [3:0]                      membyteselect,
    input  logic                            memlock,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   memdataout,
    output logic                            memrdy,
    output logic                            memexok,
    output logic                            memerr,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_ARID,
    output logic [7:0]                      M_AXI_ARLEN,
    output logic [2:0]                      M_AXI_ARSIZE,
    output logic [1:0]                      M_AXI_ARBURST,
    output logic                            M_AXI_ARLOCK,
    output logic [3:0]                      M_AXI_ARCACHE,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_AWID,
    output logic [7:0]                      M_AXI_AWLEN,
    output logic [2:0]                      M_AXI_AWSIZE,
    output logic [1:0]                      M_AXI_AWBURST,
    output logic                            M_AXI_AWLOCK,
    output logic [3:0]                      M_AXI_AWCACHE,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [3:0]                      M_AXI_WSTRB,
    output logic                            M_AXI_WLAST,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_RID,
    input  logic                            M_AXI_RLAST,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_BID,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY
);

    state_e                          state_q, state_d;
    logic                            arvalid_q, arvalid_d;
    logic                            awvalid_q, awvalid_d;
    logic                            wvalid_q, wvalid_d;
    logic                            rready_q, rready_d;
    logic                            bready_q, bready_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [3:0]                      strb_q, strb_d;
    logic [2:0]                      size_q, size_d;
    logic                            lock_q, lock_d;
    logic                            illegal_q, illegal_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                            exok_q, exok_d;
    logic                            err_q, err_d;
    sizeoff_t                        so;
    logic                            unused_bid;

    // The write response ID is not checked; only one transaction is ever outstanding.
    assign unused_bid = ^M_AXI_BID;
    assign so         = axi4strb2size(membyteselect);

    // State and handshake registers; reset abandons any transaction in flight.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q   <= IDLE;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            rready_q  <= 1'b0;
            bready_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            size_q    <= '0;
            lock_q    <= 1'b0;
            illegal_q <= 1'b0;
            rdata_q   <= '0;
            exok_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            arvalid_q <= arvalid_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            rready_q  <= rready_d;
            bready_q  <= bready_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            size_q    <= size_d;
            lock_q    <= lock_d;
            illegal_q <= illegal_d;
            rdata_q   <= rdata_d;
            exok_q    <= exok_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic: accept a request, run its channel handshakes, decode the response.
    always_comb begin
        state_d   = state_q;
        arvalid_d = arvalid_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        rready_d  = rready_q;
        bready_d  = bready_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        size_d    = size_q;
        lock_d    = lock_q;
        illegal_d = illegal_q;
        rdata_d   = rdata_q;
        exok_d    = exok_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (memop != 2'b00) begin
                    addr_d    = {memaddr, so.off} + C_M_AXI_BASEADDR;
                    size_d    = so.size;
                    lock_d    = memlock;
                    illegal_d = memop[1] & memop[0];
                    wdata_d   = memdatain;
                    strb_d    = membyteselect;
                end
                if (memop[1]) begin
                    arvalid_d = 1'b1;
                    state_d   = RADDR;
                end else if (memop[0]) begin
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = WADDR;
                end
            end
            RADDR: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RDATA;
                end
            end
            RDATA: begin
                if (M_AXI_RVALID && rready_q) begin
                    rready_d = 1'b0;
                    rdata_d  = M_AXI_RDATA;
                    exok_d   = lock_q && (M_AXI_RRESP == RESP_EXOKAY);
                    err_d    = resp_is_err(M_AXI_RRESP) || illegal_q || (M_AXI_RID != C_M_AXI_ID) || !M_AXI_RLAST;
                    state_d  = IDLE;
                end
            end
            WADDR: begin
                if (M_AXI_AWREADY) awvalid_d = 1'b0;
                if (M_AXI_WREADY) wvalid_d = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WRESP;
                end
            end
            WRESP: begin
                if (M_AXI_BVALID && bready_q) begin
                    bready_d = 1'b0;
                    exok_d   = lock_q && (M_AXI_BRESP == RESP_EXOKAY);
                    err_d    = resp_is_err(M_AXI_BRESP);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign memrdy        = (state_q == IDLE);
    assign memdataout    = rdata_q;
    assign memexok       = exok_q;
    assign memerr        = err_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_ARID    = C_M_AXI_ID;
    assign M_AXI_ARLEN   = 8'd0;
    assign M_AXI_ARSIZE  = size_q;
    assign M_AXI_ARBURST = BURST_INCR;
    assign M_AXI_ARLOCK  = lock_q;
    assign M_AXI_ARCACHE = AXI_CACHE;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_AWID    = C_M_AXI_ID;
    assign M_AXI_AWLEN   = 8'd0;
    assign M_AXI_AWSIZE  = size_q;
    assign M_AXI_AWBURST = BURST_INCR;
    assign M_AXI_AWLOCK  = lock_q;
    assign M_AXI_AWCACHE = AXI_CACHE;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = strb_q;
    assign M_AXI_WLAST   = wvalid_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_RREADY  = rready_q;
    assign M_AXI_BREADY  = bready_q;

endmodule
